// File: rtl/mult_pkg.sv
//------------------------------------------------------------------------------
// Module   : mult_pkg
// Purpose  : Shared state encoding and operand-extension helper for seq_multiplier.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  localparam int unsigned c_MIN_WIDTH = 2;
  localparam int unsigned c_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Extension bit placed above an operand's MSB: copies the sign in signed mode, 0 otherwise.
  function automatic logic ext_w1(input logic msb, input logic signed_mode);
    return signed_mode & msb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_step.sv
//------------------------------------------------------------------------------
// Module   : mult_step
// Purpose  : One combinational add/subtract-and-shift iteration of the multiplier.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mult_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_m,
  input  logic             i_last,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_a_next,
  output logic             o_b_in,
  output logic             o_x_next
);

  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_d_ext;
  logic [WIDTH:0] w_opnd;
  logic [WIDTH:0] w_sum;

  assign w_a_ext = {ext_w1(i_a[WIDTH-1], i_mode), i_a};
  assign w_d_ext = {ext_w1(i_d[WIDTH-1], i_mode), i_d};

  // Negation happens at WIDTH+1 bits so that -(-2^(N-1)) stays representable.
  always_comb begin
    w_opnd = '0;
    if (i_m) begin
      if (i_last && i_mode) begin
        w_opnd = '0 - w_d_ext;
      end else begin
        w_opnd = w_d_ext;
      end
    end
  end

  assign w_sum    = w_a_ext + w_opnd;
  assign o_a_next = w_sum[WIDTH:1];
  assign o_b_in   = w_sum[0];
  assign o_x_next = i_mode & w_sum[WIDTH];

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
//------------------------------------------------------------------------------
// Module   : seq_multiplier
// Purpose  : Sequential shift-add N x N multiplier (signed/unsigned), product in A:B.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load_B,
  input  logic             Clear_A,
  input  logic             Start,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned      c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_x;
  logic [WIDTH-1:0]  r_d;
  logic              r_mode;
  logic [c_CW-1:0]   r_count;

  state_t            w_state_nxt;
  logic [WIDTH-1:0]  w_a_nxt;
  logic [WIDTH-1:0]  w_b_nxt;
  logic              w_x_nxt;
  logic [WIDTH-1:0]  w_d_nxt;
  logic              w_mode_nxt;
  logic [c_CW-1:0]   w_count_nxt;

  logic              w_last;
  logic [WIDTH-1:0]  w_step_a;
  logic              w_step_b_in;
  logic              w_step_x;

  assign w_last = (r_count == c_LAST);

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a      (r_a),
    .i_d      (r_d),
    .i_m      (r_b[0]),
    .i_last   (w_last),
    .i_mode   (r_mode),
    .o_a_next (w_step_a),
    .o_b_in   (w_step_b_in),
    .o_x_next (w_step_x)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= 1'b0;
      r_d     <= '0;
      r_mode  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_x     <= w_x_nxt;
      r_d     <= w_d_nxt;
      r_mode  <= w_mode_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_x_nxt     = r_x;
    w_d_nxt     = r_d;
    w_mode_nxt  = r_mode;
    w_count_nxt = r_count;

    case (r_state)
      IDLE, DONE: begin
        // Load_B and Clear_A outrank Start and freeze the state for that cycle.
        if (Load_B) begin
          w_b_nxt = Din;
          w_a_nxt = '0;
          w_x_nxt = 1'b0;
        end else if (Clear_A) begin
          w_a_nxt = '0;
          w_x_nxt = 1'b0;
        end else if (r_state == IDLE) begin
          if (Start) begin
            w_d_nxt     = Din;
            w_mode_nxt  = Signed_Mode;
            w_a_nxt     = '0;
            w_x_nxt     = 1'b0;
            w_count_nxt = '0;
            w_state_nxt = RUN;
          end
        end else if (!Start) begin
          w_state_nxt = IDLE;
        end
      end

      RUN: begin
        w_a_nxt = w_step_a;
        w_b_nxt = {w_step_b_in, r_b[WIDTH-1:1]};
        w_x_nxt = w_step_x;
        if (w_last) begin
          w_count_nxt = '0;
          w_state_nxt = DONE;
        end else begin
          w_count_nxt = r_count + c_CW'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign A    = r_a;
  assign B    = r_b;
  assign X    = r_x;
  assign Busy = (r_state == RUN);
  assign Done = (r_state == DONE);

endmodule

`default_nettype wire

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier for N-bit operands, signed or unsigned, with a 2N-bit product held in the A:B register pair plus sign/extension bit X.
- Successor to the fixed 8-bit lab multiplier:
  - completes one add/subtract plus shift per clock instead of two;
  - captures the multiplicand at Start;
  - clears A automatically at Start;
  - exposes Busy/Done handshake.
- Sits between the switch/button synchronizers and the hex display drivers in the multiplier top level.
- All inputs arrive already synchronized to Clk.

Parameters:
- WIDTH, 8, operand width N; legal range 2..32.

Ports:
- Clk          in   1      system clock, all state updates on rising edge
- Reset_n      in   1      reset, synchronous, active-low
- Load_B       in   1      load Din into B, clear A and X (IDLE/DONE only)
- Clear_A      in   1      clear A and X (IDLE/DONE only)
- Start        in   1      level request to begin a multiply
- Signed_Mode  in   1      1 = two's-complement operands, 0 = unsigned; sampled at Start
- Din          in   WIDTH  multiplicand (at Start) or multiplier (at Load_B)
- A            out  WIDTH  upper product half / accumulator
- B            out  WIDTH  lower product half / multiplier shift register
- X            out  1      extension bit: product sign in signed mode, 0 in unsigned mode
- Busy         out  1      high while in RUN
- Done         out  1      high while in DONE

Behaviour:
- Reset (Reset_n low at a rising edge):
  - A, B, X, D, mode, count cleared to 0; state = IDLE.
  - Busy = 0, Done = 0.
  - Reset has priority over everything, including mid-RUN; the partial result is discarded.
- States: IDLE, RUN, DONE. Busy = (state == RUN). Done = (state == DONE).
- IDLE and DONE, priority order when inputs coincide:
  - Load_B: B <= Din; A <= 0; X <= 0; state unchanged; Start ignored this cycle.
  - else Clear_A: A <= 0; X <= 0; Start ignored this cycle.
  - else IDLE with Start = 1:
    - D <= Din; mode <= Signed_Mode; A <= 0; X <= 0; count <= 0.
    - State -> RUN.
- DONE with Start = 0: -> IDLE. DONE with Start = 1: hold.
  - One Start assertion therefore yields exactly one multiply.
- RUN: one iteration per clock, with M = B[0] and last = (count == WIDTH-1).
  - Operand: if M = 0, opnd = 0. If M = 1, opnd = +D, except opnd = -D when last and mode = signed.
  - Extension: ext() is a sign-extension to WIDTH+1 bits in signed mode and a zero-extension in unsigned mode.
  - Sum: S = ext(A) + ext(opnd), modulo 2^(WIDTH+1).
  - Register update:
    - A <= S[WIDTH:1]
    - B <= {S[0], B[WIDTH-1:1]}
    - X <= mode ? S[WIDTH] : 0
  - Sequencing: count <= count + 1; if last, state -> DONE.
- Latency: Start sampled at edge k -> Busy high after edges k..k+WIDTH-1 -> Done high after edge k+WIDTH. Total WIDTH+1 clocks.
- Result: {A,B} = D*B0 as a 2N-bit product, two's complement in signed mode.
  - No overflow is possible.
  - Signed (-2^(N-1))*(-2^(N-1)) is exact.
- Load_B and Clear_A are ignored in RUN. Din changes during RUN have no effect.
- count width is $clog2(WIDTH); it never exceeds WIDTH-1.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, RUN, DONE};
  - function ext_w1 (sign/zero extension selected by mode).
- Sub-module mult_step (combinational): A, D, M, last, mode -> next A, shift-in bit for B, X.
  - Instantiated once.
- seq_multiplier holds the FSM, counter and registers.

Test Plan:
- WIDTH=8 signed: Load_B with Din=0x07, then Start with Din=0xC5 -> Done after 9 clocks; A=0xFE, B=0x63, X=1 (-413). Busy high exactly 8 cycles.
- WIDTH=8 unsigned: B=0xFF, D=0xFF -> A=0xFE, B=0x01, X=0. Same operands signed -> A=0x00, B=0x01, X=0.
- WIDTH=8 signed corner: B=0x80, D=0x80 -> A=0x40, B=0x00, X=0. Also B=0x00, D=0x80 -> all zero.
- Handshake: hold Start high 30 cycles -> exactly one RUN, Done held. Drop Start -> IDLE next clock. Re-raise -> second multiply, with A auto-cleared.
- Reset and coincidence: drive Reset_n low at iteration 4 -> next edge A=B=X=0, IDLE, Busy=0. Assert Load_B and Start in the same cycle -> B loaded, no RUN that cycle.
- WIDTH=16 signed: B=0x8000, D=0x7FFF -> A=0xC000, B=0x8000, X=1; Done after 17 clocks.
